// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: top-level multicycle control FSM for the RV64 subset core
// (R-type, ld, sd, beq). It sequences the shared memory port, IR, PC, ALU and
// register file over several cycles per instruction.
//
// Ports:
//   clk, reset      - core clock; asynchronous active-low reset
//   opcode          - IR[6:0], valid from DECODE onward
//   zero            - ALU zero flag (used only in EXEC for beq)
//   mem_ready       - memory handshake completion (may coincide with mem_req rising)
//   mem_req/mem_we/i_or_d             - memory request, write enable, address select
//   ir_write/pc_write/pc_src          - IR latch, PC update and PC source
//   alu_src/alu_op                    - ALU operand-B select and operation class
//   reg_write/mem_to_reg              - register write enable and write-back select
//   illegal/bus_err - sticky trap flags (unsupported opcode / memory wait timeout)
//   state_dbg       - current state encoding
//
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to add the 32-bit instret
// and stall_cnt performance counters.
//
// Control outputs are decoded from the current state (plus mem_ready/zero for
// the same-cycle handshake actions); state, trap flags and counters are registered.

module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_dbg
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Instruction class captured in DECODE so later states do not depend on IR timing
  typedef enum logic [1:0] {
    K_RTYPE = 2'd0,
    K_LD    = 2'd1,
    K_SD    = 2'd2,
    K_BEQ   = 2'd3
  } kind_t;

  state_t           state, state_nxt;
  kind_t            kind, kind_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             illegal_set;
  logic             bus_err_set;

  // Last stalled cycle allowed before a missing mem_ready becomes a bus error
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

  // State, instruction class, wait counter and sticky trap flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      kind     <= K_RTYPE;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      kind     <= kind_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (illegal_set) illegal <= 1'b1;
      if (bus_err_set) bus_err <= 1'b1;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt    = state;
    kind_nxt     = kind;
    wait_cnt_nxt = '0;
    illegal_set  = 1'b0;
    bus_err_set  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src      = 1'b0;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;

    unique case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = S_TRAP;
          bus_err_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end

      S_DECODE: begin
        state_nxt = S_EXEC;
        unique case (opcode)
          OP_RTYPE: kind_nxt = K_RTYPE;
          OP_LD:    kind_nxt = K_LD;
          OP_SD:    kind_nxt = K_SD;
          OP_BEQ:   kind_nxt = K_BEQ;
          default: begin
            state_nxt   = S_TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end

      S_EXEC: begin
        unique case (kind)
          K_RTYPE: begin
            alu_op    = ALU_FUNCT;
            state_nxt = S_WB;
          end
          K_LD, K_SD: begin
            alu_op    = ALU_ADD;
            alu_src   = 1'b1;
            state_nxt = S_MEM;
          end
          K_BEQ: begin
            alu_op    = ALU_SUB;
            pc_write  = zero;
            pc_src    = zero;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = (kind == K_SD);
        if (mem_ready) begin
          state_nxt = (kind == K_SD) ? S_FETCH : S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = S_TRAP;
          bus_err_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (kind == K_LD);
        state_nxt  = S_FETCH;
      end

      S_TRAP: state_nxt = S_TRAP;

      default: state_nxt = S_FETCH;
    endcase

    // Handshake-driven strobes stay quiet while reset is held
    if (!reset) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

  assign state_dbg = state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;

  // An instruction retires when control returns to FETCH from a working state
  assign retire = (state_nxt == S_FETCH) &&
                  ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret   <= '0;
      stall_cnt <= '0;
    end else begin
      if (retire)                instret   <= instret + 32'd1;
      if (mem_req && !mem_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV64 subset core (R-type, ld, sd, beq).
- Sequences one shared memory port, the IR, PC, ALU and register file over several cycles per instruction.
- Drives the datapath select lines, including the ALU operand select for the sign-extended immediate built from IR fields.
- Sits between the IR/flags and the datapath muxes; the core's single top-level controller.

Parameters:
- WAIT_LIMIT, 16: maximum cycles a memory request may wait for mem_ready before a bus-error trap.
- CNT_W, 5: width of the internal wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake completion; may be high in the same cycle mem_req rises.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store, 0 = read (fetch or load).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  latch instruction into IR.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target (PC + imm).
- alu_src  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  00 add, 01 subtract (beq), 10 decode by funct fields.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  write-back select: 1 = load data.
- illegal  out  1  sticky: unsupported opcode trapped.
- bus_err  out  1  sticky: memory wait exceeded WAIT_LIMIT.
- state_dbg  out  3  current state encoding.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (reset=0, asynchronous):
  - state=FETCH, wait counter=0, illegal=0, bus_err=0.
  - All control outputs are combinational from state, so all are 0 during reset except mem_req=1 (FETCH).
- Outputs default to 0 in every state unless listed below.
- FETCH: mem_req=1, i_or_d=0, mem_we=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0 in that same cycle; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no outputs. Next state by opcode:
  - 0110011, 0000011, 0100011, 1100011 → EXEC.
  - Any other opcode → TRAP; illegal set at the transition edge.
- EXEC:
  - R-type: alu_op=10, alu_src=0; next WB.
  - ld/sd: alu_op=00, alu_src=1; next MEM.
  - beq: alu_op=01, alu_src=0. If zero=1, pc_write=1 and pc_src=1 in this cycle. Next FETCH regardless of zero.
- MEM: mem_req=1, i_or_d=1, mem_we=1 for sd and 0 for ld. Hold until mem_ready.
  - On mem_ready: sd → FETCH, ld → WB.
- WB: reg_write=1, mem_to_reg=1 for ld and 0 for R-type; next FETCH.
- TRAP: absorbing; all control outputs 0, mem_req=0. Exit only via reset.
- Wait counter (FETCH and MEM only):
  - Clears on entry to FETCH or MEM and on mem_ready.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches WAIT_LIMIT without mem_ready: next state TRAP, bus_err set.
  - If mem_ready arrives in the limit cycle, it wins: normal transition, no error.
- Latency with zero-wait memory (mem_ready same cycle): beq 3 cycles, R-type 4, sd 4, ld 5.
- Reset mid-instruction: FSM returns to FETCH immediately; PC/IR contents are not this block's concern.
- mem_req is never deasserted while waiting; mem_we and i_or_d stay stable for the whole wait.
- The zero flag is sampled only in EXEC for beq.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, adds outputs instret (32 bit) and stall_cnt (32 bit), both reset to 0:
  - instret increments on every transition into FETCH from EXEC (beq), MEM (sd) or WB.
  - stall_cnt increments every cycle mem_req=1 and mem_ready=0.
  - Both wrap at 2^32 with no saturation.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- R-type 0x00B50533 with mem_ready tied 1 → states 0,1,2,4,0; reg_write=1 exactly in cycle 4; alu_op=10 in EXEC.
- ld 0x0085B503 with mem_ready delayed 3 cycles in MEM:
  - MEM held 4 cycles with mem_req=1, i_or_d=1, mem_we=0.
  - WB then asserts mem_to_reg=1 and reg_write=1.
- beq 0x00B50463:
  - With zero=1: pc_write=1 and pc_src=1 in EXEC.
  - With zero=0: no pc_write in EXEC.
  - Both cases return to FETCH.
- opcode 0x7F after fetch → TRAP at cycle 3; illegal=1; mem_req stays 0 for 20 further cycles; reset=0 clears to FETCH.
- WAIT_LIMIT=16 with mem_ready never asserted in FETCH → TRAP after 16 stalled cycles with bus_err=1. Repeat with mem_ready on the 16th cycle → DECODE, bus_err=0.
- With MULTICYCLE_CTRL_PERF_EN defined, run sd then ld, each with 2 wait cycles in MEM and zero-wait fetch → instret=2, stall_cnt=4.
